// File: rtl/rom_frame_reader.sv
// Streams one image frame out of a synchronous ROM as a valid/ready pixel stream
// with column/row coordinates and frame markers, buffered by a two-entry FIFO.
module rom_frame_reader #(
    parameter int IMG_W  = 960,
    parameter int IMG_H  = 540,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic [9:0]        m_col,
    output logic [9:0]        m_row,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [9:0]        LAST_COL  = 10'(IMG_W - 1);
    localparam logic [9:0]        LAST_ROW  = 10'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [ADDR_W-1:0] r_addrCnt;
    logic              r_inflight;
    logic [7:0]        r_fifoMem [2];
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_fifoCount;
    logic [9:0]        r_col;
    logic [9:0]        r_row;
    logic              r_done;

    logic              w_valid;
    logic              w_xfer;
    logic              w_eol;
    logic              w_eof;
    logic              w_startFrame;
    logic              w_abortFrame;
    logic              w_issue;
    logic              w_lastIssue;
    logic              w_eofXfer;
    logic [2:0]        w_occupancy;

    assign w_valid     = (r_fifoCount != 2'd0);
    assign w_xfer      = w_valid & m_ready;
    assign w_eol       = (r_col == LAST_COL);
    assign w_eof       = w_eol & (r_row == LAST_ROW);
    assign w_occupancy = {1'b0, r_fifoCount} + {2'b00, r_inflight};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_nextState = IDLE;
                end else if (w_lastIssue) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (abort || w_eofXfer) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // A read is only issued when the word it returns is guaranteed a FIFO slot.
    always_comb begin
        busy         = (r_state != IDLE);
        w_startFrame = (r_state == IDLE) && start;
        w_abortFrame = (r_state != IDLE) && abort;
        w_issue      = (r_state == RUN) && !abort &&
                       (w_occupancy <= (3'd1 + {2'b00, w_xfer}));
        w_lastIssue  = w_issue && (r_addrCnt == LAST_ADDR);
        w_eofXfer    = (r_state == DRAIN) && !abort && w_xfer && w_eof;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addrCnt    <= '0;
            r_inflight   <= 1'b0;
            r_fifoMem[0] <= 8'd0;
            r_fifoMem[1] <= 8'd0;
            r_wrPtr      <= 1'b0;
            r_rdPtr      <= 1'b0;
            r_fifoCount  <= 2'd0;
            r_col        <= 10'd0;
            r_row        <= 10'd0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_eofXfer;
            if (w_startFrame) begin
                r_addrCnt   <= '0;
                r_inflight  <= 1'b0;
                r_wrPtr     <= 1'b0;
                r_rdPtr     <= 1'b0;
                r_fifoCount <= 2'd0;
                r_col       <= 10'd0;
                r_row       <= 10'd0;
            end else if (w_abortFrame) begin
                r_inflight  <= 1'b0;
                r_wrPtr     <= 1'b0;
                r_rdPtr     <= 1'b0;
                r_fifoCount <= 2'd0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue && !w_lastIssue) begin
                    r_addrCnt <= r_addrCnt + 1'b1;
                end
                if (r_inflight) begin
                    r_fifoMem[r_wrPtr] <= rom_dout;
                    r_wrPtr            <= ~r_wrPtr;
                end
                if (w_xfer) begin
                    r_rdPtr <= ~r_rdPtr;
                    if (w_eol) begin
                        r_col <= 10'd0;
                        r_row <= w_eof ? 10'd0 : r_row + 10'd1;
                    end else begin
                        r_col <= r_col + 10'd1;
                    end
                end
                r_fifoCount <= r_fifoCount + {1'b0, r_inflight} - {1'b0, w_xfer};
            end
        end
    end

    assign done     = r_done;
    assign rom_addr = r_addrCnt;
    assign m_valid  = w_valid;
    assign m_data   = r_fifoMem[r_rdPtr];
    assign m_col    = r_col;
    assign m_row    = r_row;
    assign m_sof    = w_valid & (r_col == 10'd0) & (r_row == 10'd0);
    assign m_eol    = w_valid & w_eol;
    assign m_eof    = w_valid & w_eof;

endmodule
